regfile_alu_seq: RTL and testbench

//  Multi-cycle instruction sequencer/ALU that drives the 4x8 register file's single

---
 rtl/regfile_alu_seq_if.sv | 33 +++
 rtl/regfile_alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_regfile_alu_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_alu_seq_if.sv
// Bundle of the instruction handshake, register-file ports, retire pulse and flags.
// The sequencer takes the slave side; whatever issues instructions and models the regfile takes master.
interface regfile_alu_seq_if #(
    parameter int Width = 8,
    parameter int Addr  = 2
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       op;
    logic [Addr-1:0]  rd;
    logic [Addr-1:0]  rs1;
    logic [Addr-1:0]  rs2;
    logic [Width-1:0] imm;
    logic [Width-1:0] r_data;
    logic [Addr-1:0]  r_addr;
    logic             r_en;
    logic [Addr-1:0]  w_addr;
    logic [Width-1:0] w_data;
    logic             w_en;
    logic             done;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output instr_valid, op, rd, rs1, rs2, imm, r_data,
        input  instr_ready, r_addr, r_en, w_addr, w_data, w_en, done, flag_z, flag_c
    );

    modport slave (
        input  instr_valid, op, rd, rs1, rs2, imm, r_data,
        output instr_ready, r_addr, r_en, w_addr, w_data, w_en, done, flag_z, flag_c
    );
endinterface

// File: rtl/regfile_alu_seq.sv
// Multi-cycle sequencer/ALU: reads operands one at a time through the regfile's single
// read port, computes in EXEC and writes the result back through the single write port.
module regfile_alu_seq #(
    parameter int Width = 8,
    parameter int Addr  = 2
) (
    input  logic             clk,
    input  logic             rst,
    regfile_alu_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [Addr-1:0]  rd_q, rd_d;
    logic [Addr-1:0]  rs1_q, rs1_d;
    logic [Addr-1:0]  rs2_q, rs2_d;
    logic [Width-1:0] imm_q, imm_d;
    logic [Width-1:0] opa_q, opa_d;
    logic [Width-1:0] opb_q, opb_d;
    logic [Width-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [Addr-1:0]  w_addr_q, w_addr_d;
    logic [Width-1:0] w_data_q, w_data_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;

    logic             accept;
    logic             writes;
    logic [Width:0]   sum_w;
    logic [Width:0]   diff_w;
    logic [Width-1:0] and_w;
    logic [Width-1:0] or_w;
    logic [Width-1:0] xor_w;

    genvar gi;
    generate
        for (gi = 0; gi < Width; gi++) begin : g_bitwise
            assign and_w[gi] = opa_q[gi] & opb_q[gi];
            assign or_w[gi]  = opa_q[gi] | opb_q[gi];
            assign xor_w[gi] = opa_q[gi] ^ opb_q[gi];
        end
    endgenerate

    // One extra bit: the MSB is the ADD carry-out, and for SUB it is set exactly when a < b.
    assign sum_w  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff_w = {1'b0, opa_q} - {1'b0, opb_q};

    assign accept = bus.instr_valid & bus.instr_ready;
    assign writes = (state_q == WB) && (op_q != OP_NOP);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        carry_d  = carry_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = bus.op;
                    rd_d  = bus.rd;
                    rs1_d = bus.rs1;
                    rs2_d = bus.rs2;
                    imm_d = bus.imm;
                    state_d = (bus.op == OP_LDI || bus.op == OP_NOP) ? EXEC : RD_A;
                end
            end
            RD_A: begin
                opa_d   = bus.r_data;
                state_d = (op_q == OP_MOV) ? EXEC : RD_B;
            end
            RD_B: begin
                opb_d   = bus.r_data;
                state_d = EXEC;
            end
            EXEC: begin
                carry_d = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        result_d = sum_w[Width-1:0];
                        carry_d  = sum_w[Width];
                    end
                    OP_SUB: begin
                        result_d = diff_w[Width-1:0];
                        carry_d  = diff_w[Width];
                    end
                    OP_AND:  result_d = and_w;
                    OP_OR:   result_d = or_w;
                    OP_XOR:  result_d = xor_w;
                    OP_MOV:  result_d = opa_q;
                    OP_LDI:  result_d = imm_q;
                    default: begin
                        result_d = result_q;
                        carry_d  = carry_q;
                    end
                endcase
                state_d = WB;
            end
            WB: begin
                // NOP retires with a done pulse but leaves the regfile, write bus and flags untouched.
                if (op_q != OP_NOP) begin
                    w_addr_d = rd_q;
                    w_data_d = result_q;
                    flag_z_d = (result_q == '0);
                    flag_c_d = carry_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    // Moore outputs: the write bus shows the pending write in WB and otherwise holds the last one.
    assign bus.instr_ready = (state_q == IDLE) & ~rst;
    assign bus.r_en        = (state_q == RD_A) || (state_q == RD_B);
    assign bus.r_addr      = (state_q == RD_A) ? rs1_q :
                             (state_q == RD_B) ? rs2_q : '0;
    assign bus.w_en        = writes;
    assign bus.w_addr      = writes ? rd_q : w_addr_q;
    assign bus.w_data      = writes ? result_q : w_data_q;
    assign bus.done        = (state_q == WB);
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_c      = flag_c_q;
endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench: the sequencer drives a 4x8 register file model; results, flags,
// latencies and port activity are checked against hand-computed values.
module tb_regfile_alu_seq;
    localparam logic [2:0] LDI = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] SUB = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] XOR = 3'b101;
    localparam logic [2:0] MOV = 3'b110;
    localparam logic [2:0] NOP = 3'b111;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] rf [4];
    int compared = 0;
    int mismatched = 0;

    regfile_alu_seq_if #(.Width(8), .Addr(2)) bus ();

    regfile_alu_seq #(.Width(8), .Addr(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write on the rising edge, no reset of its contents.
    assign bus.r_data = bus.r_en ? rf[bus.r_addr] : 8'h00;
    always @(posedge clk) begin
        if (bus.w_en) rf[bus.w_addr] <= bus.w_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction at a negedge, then follow it to its done pulse.
    task automatic run_instr(input string tag, input logic [2:0] op_v, input logic [1:0] rd_v,
                             input logic [1:0] rs1_v, input logic [1:0] rs2_v, input logic [7:0] imm_v,
                             input int exp_lat, input int exp_ren, input logic exp_we,
                             input logic [7:0] exp_wd, input bit hold);
        int lat = 0;
        int ren = 0;
        int wen = 0;
        bit got = 0;
        @(negedge clk);
        bus.op  = op_v;
        bus.rd  = rd_v;
        bus.rs1 = rs1_v;
        bus.rs2 = rs2_v;
        bus.imm = imm_v;
        bus.instr_valid = 1'b1;
        #1 chk({tag, "_ready_idle"}, 32'(bus.instr_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.instr_valid = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (bus.r_en) ren++;
            if (bus.w_en) wen++;
            chk({tag, "_ready_busy"}, 32'(bus.instr_ready), 32'd0);
            if (bus.done) got = 1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_r_en_cycles"}, 32'(ren), 32'(exp_ren));
        chk({tag, "_w_en_cycles"}, 32'(wen), exp_we ? 32'd1 : 32'd0);
        if (exp_we) begin
            chk({tag, "_w_addr"}, 32'(bus.w_addr), 32'(rd_v));
            chk({tag, "_w_data"}, 32'(bus.w_data), 32'(exp_wd));
        end
        $display("txn %s op=%0d rd=%0d rs1=%0d rs2=%0d imm=%02h latency=%0d w_data=%02h",
                 tag, op_v, rd_v, rs1_v, rs2_v, imm_v, lat, bus.w_data);
    endtask

    task automatic flags(input string tag, input logic ez, input logic ec);
        @(negedge clk);
        chk({tag, "_flag_z"}, 32'(bus.flag_z), 32'(ez));
        chk({tag, "_flag_c"}, 32'(bus.flag_c), 32'(ec));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wen;
        int dn;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.op  = NOP;
        bus.rd  = 2'd0;
        bus.rs1 = 2'd0;
        bus.rs2 = 2'd0;
        bus.imm = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_w_en", 32'(bus.w_en), 32'd0);
        chk("rst_r_en", 32'(bus.r_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_w_addr", 32'(bus.w_addr), 32'd0);
        chk("rst_w_data", 32'(bus.w_data), 32'd0);
        chk("rst_flag_z", 32'(bus.flag_z), 32'd0);
        chk("rst_flag_c", 32'(bus.flag_c), 32'd0);

        // 1) ADD without carry
        run_instr("ldi_r1_7f", LDI, 2'd1, 2'd0, 2'd0, 8'h7F, 2, 0, 1'b1, 8'h7F, 1'b0);
        run_instr("ldi_r2_01", LDI, 2'd2, 2'd0, 2'd0, 8'h01, 2, 0, 1'b1, 8'h01, 1'b0);
        run_instr("add_r3", ADD, 2'd3, 2'd1, 2'd2, 8'h00, 4, 2, 1'b1, 8'h80, 1'b0);
        flags("add_r3", 1'b0, 1'b0);
        chk("rf_r3_80", 32'(rf[3]), 32'h80);

        // 2) ADD wrapping to zero with carry
        run_instr("ldi_r0_ff", LDI, 2'd0, 2'd0, 2'd0, 8'hFF, 2, 0, 1'b1, 8'hFF, 1'b0);
        run_instr("ldi_r1_01", LDI, 2'd1, 2'd0, 2'd0, 8'h01, 2, 0, 1'b1, 8'h01, 1'b0);
        run_instr("add_wrap", ADD, 2'd2, 2'd0, 2'd1, 8'h00, 4, 2, 1'b1, 8'h00, 1'b0);
        flags("add_wrap", 1'b1, 1'b1);
        chk("rf_r2_00", 32'(rf[2]), 32'h00);

        // 3) SUB with borrow, rd aliasing rs1; XOR of a register with itself
        run_instr("ldi_r0_03", LDI, 2'd0, 2'd0, 2'd0, 8'h03, 2, 0, 1'b1, 8'h03, 1'b0);
        run_instr("ldi_r1_05", LDI, 2'd1, 2'd0, 2'd0, 8'h05, 2, 0, 1'b1, 8'h05, 1'b0);
        run_instr("sub_borrow", SUB, 2'd0, 2'd0, 2'd1, 8'h00, 4, 2, 1'b1, 8'hFE, 1'b0);
        flags("sub_borrow", 1'b0, 1'b1);
        chk("rf_r0_fe", 32'(rf[0]), 32'hFE);
        run_instr("xor_self", XOR, 2'd2, 2'd0, 2'd0, 8'h00, 4, 2, 1'b1, 8'h00, 1'b0);
        flags("xor_self", 1'b1, 1'b0);

        // 4) MOV (single read), then SUB to set carry, then NOP leaves flags alone
        run_instr("mov_r3", MOV, 2'd3, 2'd2, 2'd0, 8'h00, 3, 1, 1'b1, 8'h00, 1'b0);
        flags("mov_r3", 1'b1, 1'b0);
        chk("rf_r3_00", 32'(rf[3]), 32'h00);
        run_instr("sub_r1", SUB, 2'd1, 2'd1, 2'd0, 8'h00, 4, 2, 1'b1, 8'h07, 1'b0);
        flags("sub_r1", 1'b0, 1'b1);
        run_instr("nop", NOP, 2'd2, 2'd1, 2'd1, 8'hAA, 2, 0, 1'b0, 8'h00, 1'b0);
        flags("nop", 1'b0, 1'b1);
        chk("nop_r2_kept", 32'(rf[2]), 32'h00);

        // 5) instr_valid held high across three back-to-back instructions
        run_instr("held_ldi_r0", LDI, 2'd0, 2'd0, 2'd0, 8'h11, 2, 0, 1'b1, 8'h11, 1'b1);
        run_instr("held_ldi_r1", LDI, 2'd1, 2'd0, 2'd0, 8'h22, 2, 0, 1'b1, 8'h22, 1'b1);
        run_instr("held_or_r2", OR, 2'd2, 2'd0, 2'd1, 8'h00, 4, 2, 1'b1, 8'h33, 1'b1);
        bus.instr_valid = 1'b0;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("held_no_extra_done", 32'(dn), 32'd0);
        chk("held_rf_r0", 32'(rf[0]), 32'h11);
        chk("held_rf_r1", 32'(rf[1]), 32'h22);
        chk("held_rf_r2", 32'(rf[2]), 32'h33);
        run_instr("and_r3", AND, 2'd3, 2'd2, 2'd1, 8'h00, 4, 2, 1'b1, 8'h22, 1'b0);
        flags("and_r3", 1'b0, 1'b0);
        run_instr("ldi_r3_00", LDI, 2'd3, 2'd0, 2'd0, 8'h00, 2, 0, 1'b1, 8'h00, 1'b0);
        flags("ldi_r3_00", 1'b1, 1'b0);

        // 6) reset during RD_B of ADD r1: the instruction is abandoned
        @(negedge clk);
        bus.op  = ADD;
        bus.rd  = 2'd1;
        bus.rs1 = 2'd0;
        bus.rs2 = 2'd2;
        bus.imm = 8'h00;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_rd_a_r_en", 32'(bus.r_en), 32'd1);
        @(negedge clk);
        chk("abort_rd_b_r_addr", 32'(bus.r_addr), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("abort_rst_r_en", 32'(bus.r_en), 32'd0);
        chk("abort_rst_w_en", 32'(bus.w_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("abort_w_addr", 32'(bus.w_addr), 32'd0);
        chk("abort_flag_z", 32'(bus.flag_z), 32'd0);
        wen = 0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.w_en) wen++;
            if (bus.done) dn++;
        end
        chk("abort_no_w_en", 32'(wen), 32'd0);
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_r1_kept", 32'(rf[1]), 32'h22);
        $display("txn abort_add_r1 reset during RD_B w_en_cycles=%0d done_cycles=%0d", wen, dn);

        run_instr("post_rst_ldi", LDI, 2'd0, 2'd0, 2'd0, 8'h5A, 2, 0, 1'b1, 8'h5A, 1'b0);
        flags("post_rst_ldi", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
